// File: rtl/row_window_loader_pkg.sv
// Shared types and constants for the row window loader and its row registers.
// LENGTH is the row width seen by the downstream wavelet block processor.
package row_window_loader_pkg;

  localparam int LENGTH = 8;
  localparam int COL_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef logic [LENGTH-1:0][7:0] row_t;

  typedef enum logic [1:0] {
    ITER_FIRST = 2'd0,
    ITER_MID   = 2'd1,
    ITER_LAST  = 2'd2
  } iter_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } ld_state_t;

  function automatic iter_t iter_flag_of(input logic is_first, input logic is_last);
    if (is_first) return ITER_FIRST;
    if (is_last)  return ITER_LAST;
    return ITER_MID;
  endfunction

endpackage

// File: rtl/row_window_loader_slot.sv
// One LENGTH-byte window slot: single-byte indexed write plus whole-row parallel load.
// Parallel load wins over an indexed write in the same cycle.
module row_slot_writer
  import row_window_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [COL_W-1:0] wr_idx_i,
  input  logic [7:0]       wr_data_i,
  input  logic             load_en_i,
  input  row_t             load_row_i,
  output row_t             row_o
);

  row_t row_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
    end else if (load_en_i) begin
      row_q <= load_row_i;
    end else if (wr_en_i) begin
      row_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign row_o = row_q;

endmodule

// File: rtl/row_window_loader.sv
// Assembles the three-row window for the wavelet block processor from a raster
// pixel stream, then hands off with bp_en and waits for bp_result per iteration.
module row_window_loader
  import row_window_loader_pkg::*;
#(
  parameter int HEIGHT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  input  logic       pix_sof,
  output logic       pix_ready,
  output row_t       row_0,
  output row_t       row_1,
  output row_t       row_2,
  output logic [1:0] iter_flag,
  output logic       bp_en,
  input  logic       bp_result,
  output logic       busy,
  output logic       frame_done,
  output ld_state_t  state_dbg
);

  localparam int ITERS = HEIGHT / 2;
  localparam int IW    = $clog2(ITERS) + 1;
  localparam logic [IW-1:0]    LAST_ITER = IW'(ITERS - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(LENGTH - 1);

  ld_state_t        state_q;
  logic [COL_W-1:0] col_q;
  logic [1:0]       slot_q;
  logic [IW-1:0]    iter_q;
  iter_t            iter_flag_q;
  logic             pix_ready_q;
  logic             bp_en_q;
  logic             busy_q;
  logic             frame_done_q;

  logic             accept;
  logic             is_last_iter;
  logic [1:0]       last_slot;
  logic             load_fin;
  logic             sof_hit;
  logic             shift_row0;
  logic [2:0]       wr_en;
  logic [COL_W-1:0] wr_idx;

  // pix_ready is registered, so a beat transfers against the ready seen this cycle.
  always_comb begin
    accept       = pix_valid & pix_ready_q;
    is_last_iter = (iter_q == LAST_ITER);
    last_slot    = is_last_iter ? 2'd1 : 2'd2;
    load_fin     = accept && (state_q == ST_LOAD) && (col_q == LAST_COL) && (slot_q == last_slot);
    sof_hit      = accept && pix_sof && (state_q == ST_IDLE);
    shift_row0   = bp_result && (state_q == ST_WAIT) && !is_last_iter;
    wr_idx       = (state_q == ST_IDLE) ? '0 : col_q;
    wr_en        = 3'b000;
    if (sof_hit) begin
      wr_en[0] = 1'b1;
    end else if (accept && (state_q == ST_LOAD)) begin
      wr_en[slot_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      slot_q       <= '0;
      iter_q       <= '0;
      iter_flag_q  <= ITER_FIRST;
      pix_ready_q  <= 1'b0;
      bp_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      bp_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pix_ready_q <= 1'b1;
          if (sof_hit) begin
            busy_q  <= 1'b1;
            col_q   <= COL_W'(1);
            slot_q  <= 2'd0;
            iter_q  <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (col_q == LAST_COL) begin
              col_q <= '0;
              if (load_fin) begin
                pix_ready_q <= 1'b0;
                bp_en_q     <= 1'b1;
                iter_flag_q <= iter_flag_of(iter_q == '0, is_last_iter);
                state_q     <= ST_START;
              end else begin
                slot_q <= slot_q + 2'd1;
              end
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bp_result) begin
            if (is_last_iter) begin
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= ST_DONE;
            end else begin
              iter_q      <= iter_q + IW'(1);
              slot_q      <= 2'd1;
              col_q       <= '0;
              pix_ready_q <= 1'b1;
              state_q     <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          pix_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          pix_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Slot 0 also takes the previous even row from slot 2 between iterations.
  row_slot_writer u_slot0 (
    .clk(clk), .reset(reset), .wr_en_i(wr_en[0]), .wr_idx_i(wr_idx), .wr_data_i(pix_data),
    .load_en_i(shift_row0), .load_row_i(row_2), .row_o(row_0)
  );

  row_slot_writer u_slot1 (
    .clk(clk), .reset(reset), .wr_en_i(wr_en[1]), .wr_idx_i(wr_idx), .wr_data_i(pix_data),
    .load_en_i(1'b0), .load_row_i('0), .row_o(row_1)
  );

  row_slot_writer u_slot2 (
    .clk(clk), .reset(reset), .wr_en_i(wr_en[2]), .wr_idx_i(wr_idx), .wr_data_i(pix_data),
    .load_en_i(1'b0), .load_row_i('0), .row_o(row_2)
  );

  assign pix_ready  = pix_ready_q;
  assign iter_flag  = iter_flag_q;
  assign bp_en      = bp_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_row_window_loader.sv
// Directed bench for row_window_loader: full frames with and without input gaps,
// IDLE discard, long WAIT hold, mid-frame reset and a spurious done pulse.
module tb_row_window_loader;
  import row_window_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       pix_sof = 1'b0;
  logic       bp_result = 1'b0;
  logic       pix_ready, bp_en, busy, frame_done;
  logic [1:0] iter_flag;
  row_t       row_0, row_1, row_2;
  ld_state_t  state_dbg;

  always #5 clk = ~clk;

  row_window_loader #(.HEIGHT(8)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .row_0(row_0), .row_1(row_1), .row_2(row_2), .iter_flag(iter_flag),
    .bp_en(bp_en), .bp_result(bp_result), .busy(busy), .frame_done(frame_done),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [1:0] flag;
    row_t       r0;
    row_t       r1;
    row_t       r2;
  } cap_t;

  typedef struct {
    logic [1:0] flag;
    int         r0;
    int         r1;
    int         r2;
  } vec_t;

  vec_t vecs[4];
  cap_t cap[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fd_cnt = 0;
  int   fd_cyc = 0;
  int   last_res_cyc = -100;
  int   viol = 0;
  int   aa_hits = 0;
  bit   resp_en = 1'b1;
  int   man_req = 0;
  int   man_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic row_t mk_row(input int start);
    row_t r;
    for (int i = 0; i < LENGTH; i++) r[i] = 8'(start + i);
    return r;
  endfunction

  // Monitor: capture window at each start pulse, count frame_done, watch ready and 0xAA.
  initial begin
    forever begin
      @(negedge clk);
      if (bp_en) cap.push_back('{flag: iter_flag, r0: row_0, r1: row_1, r2: row_2});
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (pix_ready && (state_dbg inside {ST_START, ST_WAIT, ST_DONE})) viol++;
      for (int i = 0; i < LENGTH; i++) begin
        if (row_0[i] == 8'hAA || row_1[i] == 8'hAA || row_2[i] == 8'hAA) aa_hits++;
      end
    end
  end

  // Block processor model: done pulse 5 cycles after each start, plus on-demand pulses.
  initial begin
    int resp_cnt;
    resp_cnt = 0;
    forever begin
      @(negedge clk);
      bp_result = 1'b0;
      if (resp_cnt != 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          bp_result = 1'b1;
          last_res_cyc = cyc;
        end
      end else if (bp_en && resp_en) begin
        resp_cnt = 5;
      end
      if (man_req != man_done) begin
        bp_result = 1'b1;
        man_done++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [7:0] d, input logic sof, input bit gaps);
    bit done;
    int t;
    done = 1'b0;
    t = 0;
    if (gaps && $urandom_range(0, 1) == 0) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof = 1'b0;
      @(posedge clk);
    end
    while (!done && t < 1000) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data = d;
      pix_sof = sof;
      done = pix_ready;
      @(posedge clk);
      t++;
    end
    #1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL beat_timeout: got no ready expected ready within 1000 cycles");
    end
  endtask

  task automatic send_range(input int base, input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) send_beat(8'(base + i), (i == 0), gaps);
  endtask

  task automatic wait_frame_done(input int fd0);
    int t;
    t = 0;
    while (fd_cnt == fd0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (fd_cnt == fd0) begin
      errors++;
      checks++;
      $display("FAIL frame_done_timeout: got no pulse expected pulse within 3000 cycles");
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int base, input int cs, input int fd0);
    chk({tag, "_pulse_count"}, 64'(cap.size() - cs), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (cs + k < cap.size()) begin
        chk($sformatf("%s_p%0d_flag", tag, k + 1), 64'(cap[cs+k].flag), 64'(vecs[k].flag));
        chk($sformatf("%s_p%0d_row0", tag, k + 1), cap[cs+k].r0, mk_row(base + vecs[k].r0));
        chk($sformatf("%s_p%0d_row1", tag, k + 1), cap[cs+k].r1, mk_row(base + vecs[k].r1));
        chk($sformatf("%s_p%0d_row2", tag, k + 1), cap[cs+k].r2, mk_row(base + vecs[k].r2));
      end
    end
    chk({tag, "_frame_done_count"}, 64'(fd_cnt - fd0), 64'd1);
    chk({tag, "_frame_done_latency"}, 64'(fd_cyc), 64'(last_res_cyc + 1));
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cs, fd0, acc, aa0;

    // expected window at each start pulse: iter_flag and first pixel index of each slot
    vecs[0] = '{flag: 2'd0, r0: 0,  r1: 8,  r2: 16};
    vecs[1] = '{flag: 2'd1, r0: 16, r1: 24, r2: 32};
    vecs[2] = '{flag: 2'd1, r0: 32, r1: 40, r2: 48};
    vecs[3] = '{flag: 2'd2, r0: 48, r1: 56, r2: 48};

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("rst_bp_en", 64'(bp_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_iter_flag", 64'(iter_flag), 64'd0);
    chk("rst_row0", row_0, 64'd0);
    chk("rst_row1", row_1, 64'd0);
    chk("rst_row2", row_2, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_pix_ready", 64'(pix_ready), 64'd1);

    // 1: clean frame, pixel = index
    cs = cap.size(); fd0 = fd_cnt;
    send_range(0, 0, 63, 1'b0);
    wait_frame_done(fd0);
    check_frame("clean", 0, cs, fd0);

    // 2: same frame shape with random valid gaps, different pixel base
    cs = cap.size(); fd0 = fd_cnt;
    send_range(100, 0, 63, 1'b1);
    wait_frame_done(fd0);
    check_frame("gaps", 100, cs, fd0);

    // 3: non-sof beats in IDLE are discarded; busy rises with the sof beat
    cs = cap.size(); fd0 = fd_cnt; aa0 = aa_hits;
    repeat (3) send_beat(8'hAA, 1'b0, 1'b0);
    chk("idle_discard_busy", 64'(busy), 64'd0);
    send_beat(8'd0, 1'b1, 1'b0);
    chk("sof_busy_rise", 64'(busy), 64'd1);
    send_range(0, 1, 63, 1'b0);
    wait_frame_done(fd0);
    check_frame("discard", 0, cs, fd0);
    chk("no_0xAA_in_rows", 64'(aa_hits - aa0), 64'd0);

    // 4: processor stalls 100 cycles while input keeps offering beats
    cs = cap.size(); fd0 = fd_cnt;
    resp_en = 1'b0;
    send_range(0, 0, 23, 1'b0);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data = 8'hEE;
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      if (pix_ready) acc++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    chk("hold_accepted_beats", 64'(acc), 64'd0);
    chk("hold_state", 64'(state_dbg), 64'(ST_WAIT));
    chk("hold_row0", row_0, mk_row(0));
    chk("hold_row1", row_1, mk_row(8));
    chk("hold_row2", row_2, mk_row(16));
    chk("hold_iter_flag", 64'(iter_flag), 64'd0);
    man_req++;
    resp_en = 1'b1;
    send_range(0, 24, 63, 1'b0);
    wait_frame_done(fd0);
    check_frame("hold", 0, cs, fd0);

    // 5: reset in the middle of iteration 1 loading, then a clean frame
    send_range(0, 0, 28, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_row0", row_0, 64'd0);
    chk("midrst_row1", row_1, 64'd0);
    chk("midrst_row2", row_2, 64'd0);
    chk("midrst_iter_flag", 64'(iter_flag), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_state", 64'(state_dbg), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_pix_ready", 64'(pix_ready), 64'd1);
    cs = cap.size(); fd0 = fd_cnt;
    send_range(0, 0, 63, 1'b0);
    wait_frame_done(fd0);
    check_frame("post_reset", 0, cs, fd0);

    // 6: spurious done pulse while loading iteration 0
    cs = cap.size(); fd0 = fd_cnt;
    send_range(0, 0, 9, 1'b0);
    man_req++;
    send_range(0, 10, 63, 1'b0);
    wait_frame_done(fd0);
    check_frame("spurious", 0, cs, fd0);

    chk("ready_low_outside_load", 64'(viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
